// File: rtl/fifo_ctrl_pkg.sv
// Shared types, defaults and the round-robin pick function for the FIFO control blocks.
package fifo_ctrl_pkg;

    localparam int unsigned DEF_BURST_LEN = 4;
    localparam int unsigned DEF_TIMEOUT   = 3;
    localparam int unsigned MAX_REQ       = 8;
    localparam int unsigned MAX_ID_W      = 3;

    typedef enum logic {ARB, BURST} arb_state_e;

    // First set bit of req at or after ptr, wrapping modulo n; 0 when req is empty.
    function automatic logic [MAX_ID_W-1:0] rr_next(
        input logic [MAX_REQ-1:0]  req,
        input logic [MAX_ID_W-1:0] ptr,
        input int unsigned         n
    );
        logic [MAX_ID_W-1:0] win;
        logic                found;
        int unsigned         idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = (32'(ptr) + i) % n;
            if (i < n && !found && req[MAX_ID_W'(idx)]) begin
                win   = MAX_ID_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick with a registered pointer that moves past the
// current owner on each advance strobe.
module rr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    input  logic [ID_W-1:0]    cur_id,
    output logic [ID_W-1:0]    pick,
    output logic               any_req
);

    logic [ID_W-1:0] rr_ptr;

    assign pick    = ID_W'(rr_next(MAX_REQ'(req), MAX_ID_W'(rr_ptr), NUM_REQ));
    assign any_req = |req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + ID_W'(1);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the byte-wide FIFO write port between producers,
// one burst per grant, with an idle timeout that releases a stalled owner.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_w_data,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          burst_done,
    output logic                          burst_partial
);

    localparam int unsigned BC_W = $clog2(BURST_LEN + 1);
    localparam int unsigned IC_W = $clog2(TIMEOUT + 1);

    arb_state_e      state;
    logic [BC_W-1:0] beat_cnt;
    logic [IC_W-1:0] idle_cnt;
    logic [ID_W-1:0] pick;
    logic            any_req;
    logic            in_burst;
    logic            accept;
    logic            idle;
    logic            last_beat;
    logic            timed_out;

    // Full-while-valid is backpressure: neither accept nor idle, so both counters hold.
    always_comb begin
        in_burst  = (state == BURST);
        accept    = in_burst && req_valid[grant_id] && !fifo_full;
        idle      = in_burst && !req_valid[grant_id];
        last_beat = accept && (beat_cnt == BC_W'(BURST_LEN - 1));
        timed_out = idle && (idle_cnt == IC_W'(TIMEOUT - 1));
    end

    assign busy          = in_burst;
    assign fifo_wr_en    = accept;
    assign burst_done    = last_beat || timed_out;
    assign burst_partial = timed_out;

    always_comb begin
        req_ready = '0;
        if (in_burst && !fifo_full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        fifo_w_data = '0;
        if (in_burst) begin
            fifo_w_data = req_data[32'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (burst_done),
        .cur_id  (grant_id),
        .pick    (pick),
        .any_req (any_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            grant_id <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (any_req) begin
                        state    <= BURST;
                        grant_id <= pick;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                    end
                end
                BURST: begin
                    if (last_beat || timed_out) begin
                        state    <= ARB;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + BC_W'(1);
                        idle_cnt <= '0;
                    end else if (idle) begin
                        idle_cnt <= idle_cnt + IC_W'(1);
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the byte-wide write port of the 8-to-32 adaptive-width FIFO between `NUM_REQ` independent byte producers. It grants one producer at a time for a burst of up to `BURST_LEN` bytes, which is one 32-bit output word when `BURST_LEN` = 4, so producers' bytes are not interleaved within a word. A stalled producer releases the port after a programmable idle timeout. Sits between SoC producer modules and the FIFO write interface; the FIFO read side is untouched.

## Interface
- `NUM_REQ`, 4: number of producers, 2..8.
- `DATA_WIDTH`, 8: producer and FIFO write data width.
- `BURST_LEN`, 4: bytes per full grant; must be ≥1.
- `TIMEOUT`, 3: consecutive no-valid cycles inside a burst before the grant is released; must be ≥1.
- `ID_W`, `$clog2(NUM_REQ)`: derived; grant index width.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-producer byte valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  producer i's byte in slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  per-producer accept; a byte transfers when valid && ready.
- `fifo_w_data`  out  DATA_WIDTH  to FIFO `w_data`.
- `fifo_wr_en`  out  1  to FIFO `wr_en`.
- `fifo_full`  in  1  from FIFO `full`.
- `grant_id`  out  ID_W  current owner; valid while `busy`.
- `busy`  out  1  a burst is in progress.
- `burst_done`  out  1  one-cycle pulse on the last cycle of any burst.
- `burst_partial`  out  1  qualifies `burst_done`; burst ended by timeout.

## Operation
- FSM states: ARB, BURST. Reset state: ARB.
- ARB:
  - If any `req_valid`, pick the first requester at or after `rr_ptr` (wrapping modulo `NUM_REQ`).
  - Register it into `grant_id`, clear `beat_cnt` and `idle_cnt`, and go to BURST.
  - Otherwise stay in ARB.
  - No transfers occur in ARB.
- BURST:
  - `req_ready[grant_id]` = !`fifo_full`; all other ready bits are 0.
  - `fifo_wr_en` = `req_valid[grant_id]` && !`fifo_full`.
  - `fifo_w_data` = `req_data` slice of `grant_id`, passed through combinationally.
  - Accepted beat: `beat_cnt`++ and `idle_cnt` cleared.
  - Cycle with `req_valid[grant_id]`=0: `idle_cnt`++.
  - Cycle with valid=1 but `fifo_full`=1: this is backpressure, not idle. `idle_cnt` holds and the grant is kept indefinitely.
  - Exit on the accepted beat that makes `beat_cnt` == `BURST_LEN`: `burst_done`=1, `burst_partial`=0.
  - Exit when `idle_cnt` reaches `TIMEOUT`, i.e. the TIMEOUT-th consecutive idle cycle: `burst_done`=1, `burst_partial`=1.
  - On either exit: `rr_ptr` ← `grant_id`+1 (mod `NUM_REQ`), go to ARB.
- Zero-beat burst (timeout with no accepted beats) is legal and rotates `rr_ptr`.
- `beat_cnt` width is `$clog2(BURST_LEN+1)`; `idle_cnt` width is `$clog2(TIMEOUT+1)`. Neither counter can exceed its limit.
- `fifo_wr_en` is never asserted while `fifo_full`=1, and never for a non-granted producer.

## Timing
- Reset values (async assert, sync-safe deassert): state=ARB, `rr_ptr`=0, `grant_id`=0, counters=0.
- Outputs during reset: `busy`=0, `req_ready`=0, `fifo_wr_en`=0, `fifo_w_data`=0, `burst_done`=0, `burst_partial`=0.
- Grant latency: `req_valid` seen in cycle N (ARB) → `busy` and ready from cycle N+1. First byte can transfer in N+1.
- Back-to-back bursts cost one ARB bubble cycle. Maximum throughput is `BURST_LEN` bytes per `BURST_LEN`+1 cycles.
- The data path is purely combinational in BURST; there is no added pipeline latency to the FIFO.
- Producers must hold `req_data` stable while valid && !ready. Dropping valid without a transfer is permitted and counts as idle.
- Reset asserted mid-burst: burst abandoned immediately, no `burst_done`, `rr_ptr` returns to 0. Bytes already written remain in the FIFO; the FIFO has its own reset.

## Structure
- Shared package `fifo_ctrl_pkg` contains:
  - `typedef enum logic {ARB, BURST} arb_state_e`.
  - Function `rr_next(req, ptr)` returning the winning index.
  - Default localparams `DEF_BURST_LEN`=4 and `DEF_TIMEOUT`=3, reused by a future read-side scheduler.
- One sub-module `rr_arbiter`: combinational pick plus a registered `rr_ptr` update on an `advance` strobe. The FSM, counters and data mux live in `fifo_wr_arbiter`.

## Test plan
- Single producer, no backpressure: req 0 streams 0x11,0x22,0x33,0x44 → `fifo_wr_en` for 4 consecutive cycles starting 1 cycle after valid; FIFO `r_data`=0x44332211; `burst_done`=1 and `burst_partial`=0 on the 4th beat.
- All four requesting continuously, each sending bytes 0xi0..0xi3 → grants ordered 0,1,2,3,0 with one ARB cycle between bursts. Each FIFO 32-bit word contains bytes from exactly one producer.
- Backpressure: `fifo_full` held high for 10 cycles mid-burst with valid=1 → no `fifo_wr_en`, grant held, no timeout. The burst completes after full drops.
- Stalled producer: req 1 sends 2 bytes, then drops valid → after 3 idle cycles `burst_done`=1 and `burst_partial`=1; next grant goes to req 2 if it is requesting.
- Zero-beat grant: req 3 pulses valid for 1 cycle only → grant 3, timeout after 3 cycles, no write, `rr_ptr`=0.
- Reset: `rst_n` low mid-burst after 2 beats → all outputs 0 asynchronously. After release, a pending req 2 is granted; the pick starts from `rr_ptr`=0.
